// File: rtl/por_seq_ctrl.sv
// Post-POR reset-release sequencer: releases N_DOM reset domains in index order,
// with a programmable inter-release delay, per-domain ack timeout and sticky error.
module por_seq_ctrl #(
    parameter int N_DOM  = 4,
    parameter int DLY_W  = 8,
    parameter int ACK_TO = 16,
    localparam int DOM_W = (N_DOM > 1) ? $clog2(N_DOM) : 1,
    localparam int TO_W  = $clog2(ACK_TO + 1)
) (
    input  logic             osc_ck,
    input  logic             rsb,
    input  logic             por,
    input  logic [DLY_W-1:0] dly_cfg,
    input  logic [N_DOM-1:0] dom_ack,
    output logic [N_DOM-1:0] dom_rstb,
    output logic             seq_done,
    output logic             seq_err,
    output logic [DOM_W-1:0] err_dom,
    output logic [2:0]       seq_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_ACK  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    localparam logic [DOM_W-1:0] LAST_DOM = DOM_W'(N_DOM - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TO - 1);

    state_e            state_q, state_d;
    logic [DOM_W-1:0]  cur_q, cur_d;
    logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [N_DOM-1:0]  dom_rstb_q, dom_rstb_d;
    logic              seq_done_q, seq_done_d;
    logic              seq_err_q, seq_err_d;
    logic [DOM_W-1:0]  err_dom_q, err_dom_d;

    // A zero delay setting still spends one cycle in WAIT.
    function automatic logic [DLY_W-1:0] dly_load(input logic [DLY_W-1:0] cfg);
        if (cfg == '0) begin
            dly_load = DLY_W'(1'b1);
        end else begin
            dly_load = cfg;
        end
    endfunction

    // Next-state and next-output logic; por aborts everything back to IDLE.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        dly_cnt_d  = dly_cnt_q;
        to_cnt_d   = to_cnt_q;
        dom_rstb_d = dom_rstb_q;
        seq_done_d = seq_done_q;
        seq_err_d  = seq_err_q;
        err_dom_d  = err_dom_q;

        if (por) begin
            state_d    = S_IDLE;
            cur_d      = '0;
            dly_cnt_d  = '0;
            to_cnt_d   = '0;
            dom_rstb_d = '0;
            seq_done_d = 1'b0;
            seq_err_d  = 1'b0;
            err_dom_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    dom_rstb_d = '0;
                    cur_d      = '0;
                    dly_cnt_d  = dly_load(dly_cfg);
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    if (dly_cnt_q <= DLY_W'(1'b1)) begin
                        // Thermometer release: earlier domains stay out of reset.
                        dom_rstb_d = dom_rstb_q | (N_DOM'(1'b1) << cur_q);
                        to_cnt_d   = '0;
                        state_d    = S_ACK;
                    end else begin
                        dly_cnt_d = dly_cnt_q - DLY_W'(1'b1);
                    end
                end
                S_ACK: begin
                    if (dom_ack[cur_q]) begin
                        if (cur_q == LAST_DOM) begin
                            seq_done_d = 1'b1;
                            state_d    = S_DONE;
                        end else begin
                            cur_d     = cur_q + DOM_W'(1'b1);
                            dly_cnt_d = dly_load(dly_cfg);
                            state_d   = S_WAIT;
                        end
                    end else if (to_cnt_q >= TO_LAST) begin
                        seq_err_d  = 1'b1;
                        err_dom_d  = cur_q;
                        dom_rstb_d = '0;
                        state_d    = S_ERR;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1'b1);
                    end
                end
                S_DONE: begin
                    dom_rstb_d = '1;
                    seq_done_d = 1'b1;
                end
                S_ERR: begin
                    dom_rstb_d = '0;
                    seq_err_d  = 1'b1;
                end
                default: begin
                    state_d    = S_IDLE;
                    dom_rstb_d = '0;
                    seq_done_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously by rsb.
    always_ff @(posedge osc_ck or negedge rsb) begin
        if (!rsb) begin
            state_q    <= S_IDLE;
            cur_q      <= '0;
            dly_cnt_q  <= '0;
            to_cnt_q   <= '0;
            dom_rstb_q <= '0;
            seq_done_q <= 1'b0;
            seq_err_q  <= 1'b0;
            err_dom_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            dly_cnt_q  <= dly_cnt_d;
            to_cnt_q   <= to_cnt_d;
            dom_rstb_q <= dom_rstb_d;
            seq_done_q <= seq_done_d;
            seq_err_q  <= seq_err_d;
            err_dom_q  <= err_dom_d;
        end
    end

    assign dom_rstb  = dom_rstb_q;
    assign seq_done  = seq_done_q;
    assign seq_err   = seq_err_q;
    assign err_dom   = err_dom_q;
    assign seq_state = state_q;

endmodule

// File: tb/tb_por_seq_ctrl.sv
// Scoreboard bench for por_seq_ctrl: expected output-change events (edge index, value)
// are queued per scenario and matched as the outputs change.
module tb_por_seq_ctrl;

    localparam int N_DOM  = 4;
    localparam int DLY_W  = 8;
    localparam int ACK_TO = 16;

    logic             osc_ck = 1'b0;
    logic             rsb;
    logic             por;
    logic [DLY_W-1:0] dly_cfg;
    logic [3:0]       dom_ack;
    logic [3:0]       dom_rstb;
    logic             seq_done;
    logic             seq_err;
    logic [1:0]       err_dom;
    logic [2:0]       seq_state;

    logic [3:0] ack_mask;
    logic [3:0] ack_force;
    logic [5:0] prev_obs;
    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    typedef struct {
        int         edge_n;
        logic [5:0] val;
    } ev_t;
    ev_t exp_q[$];

    por_seq_ctrl #(.N_DOM(N_DOM), .DLY_W(DLY_W), .ACK_TO(ACK_TO)) dut (
        .osc_ck   (osc_ck),
        .rsb      (rsb),
        .por      (por),
        .dly_cfg  (dly_cfg),
        .dom_ack  (dom_ack),
        .dom_rstb (dom_rstb),
        .seq_done (seq_done),
        .seq_err  (seq_err),
        .err_dom  (err_dom),
        .seq_state(seq_state)
    );

    always #5 osc_ck = ~osc_ck;

    task automatic drive_ack();
        dom_ack = (dom_rstb & ack_mask) | ack_force;
    endtask

    task automatic step();
        @(posedge osc_ck);
        ecnt++;
        @(negedge osc_ck);
        drive_ack();
    endtask

    task automatic push_ev(input int e, input logic [5:0] v);
        ev_t ev;
        ev.edge_n = e;
        ev.val    = v;
        exp_q.push_back(ev);
    endtask

    // Release i lands on edge (i+1)*D+i; done one edge after the last release.
    task automatic push_seq(input int d);
        int dd;
        logic [3:0] t;
        dd = (d == 0) ? 1 : d;
        for (int i = 0; i < N_DOM; i++) begin
            t = 4'((32'd1 << (i + 1)) - 32'd1);
            push_ev((i + 1) * dd + i, {2'b00, t});
        end
        push_ev(N_DOM * dd + N_DOM, 6'b01_1111);
    endtask

    task automatic run_cycles(input int n);
        logic [5:0] o;
        ev_t ev;
        for (int i = 0; i < n; i++) begin
            step();
            o = {seq_err, seq_done, dom_rstb};
            if (o !== prev_obs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change at E%0d got %b expected %b", ecnt, o, prev_obs);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.edge_n != ecnt || ev.val !== o) begin
                        errors++;
                        $display("FAIL event got E%0d %b expected E%0d %b", ecnt, o, ev.edge_n, ev.val);
                    end
                end
                prev_obs = o;
            end
        end
    endtask

    task automatic expect_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending events got %0d expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic start_seq(input int d, input logic [3:0] mask);
        por       = 1'b1;
        dly_cfg   = DLY_W'(d);
        ack_mask  = mask;
        ack_force = 4'b0000;
        step();
        prev_obs = {seq_err, seq_done, dom_rstb};
        checks++;
        if (prev_obs !== 6'b00_0000 || seq_state !== 3'd0) begin
            errors++;
            $display("FAIL por_clear got obs=%b state=%0d expected obs=000000 state=0", prev_obs, seq_state);
        end
        por  = 1'b0;
        ecnt = -1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rsb = 1'b0; por = 1'b0; dom_ack = 4'hF; dly_cfg = 8'd5;
        ack_mask = 4'hF; ack_force = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge osc_ck);
            checks++;
            if (dom_rstb !== 4'h0 || seq_done !== 1'b0 || seq_err !== 1'b0 || seq_state !== 3'd0) begin
                errors++;
                $display("FAIL reset_hold got rstb=%b done=%b err=%b state=%0d expected 0000/0/0/0",
                         dom_rstb, seq_done, seq_err, seq_state);
            end
        end
        por = 1'b1;
        rsb = 1'b1;
    endtask

    task automatic test_seq_dly3();
        start_seq(3, 4'hF);
        push_seq(3);
        run_cycles(17);
        expect_drained("seq_dly3");
        checks++;
        if (seq_state !== 3'd3) begin
            errors++; $display("FAIL dly3_done_state got %0d expected 3", seq_state);
        end
        ack_mask = 4'h0;
        run_cycles(3);
        checks++;
        if (seq_done !== 1'b1 || dom_rstb !== 4'hF) begin
            errors++; $display("FAIL done_hold got done=%b rstb=%b expected 1/1111", seq_done, dom_rstb);
        end
    endtask

    task automatic test_dly_zero();
        start_seq(0, 4'hF);
        push_seq(0);
        run_cycles(9);
        expect_drained("dly_zero");
        checks++;
        if (seq_state !== 3'd3) begin
            errors++; $display("FAIL dly0_done_state got %0d expected 3", seq_state);
        end
    endtask

    task automatic test_timeout();
        start_seq(2, 4'b1011);
        push_ev(2, 6'b00_0001);
        push_ev(5, 6'b00_0011);
        push_ev(8, 6'b00_0111);
        push_ev(24, 6'b10_0000);
        run_cycles(27);
        expect_drained("timeout");
        checks++;
        if (err_dom !== 2'd2 || seq_state !== 3'd4 || seq_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err got dom=%0d state=%0d err=%b expected 2/4/1", err_dom, seq_state, seq_err);
        end
        start_seq(3, 4'hF);
        push_seq(3);
        run_cycles(17);
        expect_drained("timeout_restart");
    endtask

    task automatic test_por_abort();
        start_seq(3, 4'hF);
        push_ev(3, 6'b00_0001);
        push_ev(7, 6'b00_0011);
        run_cycles(9);
        expect_drained("abort_pre");
        checks++;
        if (seq_state !== 3'd1 || dom_rstb !== 4'b0011) begin
            errors++; $display("FAIL abort_pre got state=%0d rstb=%b expected 1/0011", seq_state, dom_rstb);
        end
        por = 1'b1;
        push_ev(9, 6'b00_0000);
        run_cycles(1);
        expect_drained("abort");
        checks++;
        if (seq_state !== 3'd0) begin
            errors++; $display("FAIL abort_idle got state=%0d expected 0", seq_state);
        end
        por  = 1'b0;
        ecnt = -1;
        push_seq(3);
        run_cycles(17);
        expect_drained("abort_restart");
    endtask

    task automatic test_rsb_mid_ack();
        start_seq(2, 4'h0);
        push_ev(2, 6'b00_0001);
        run_cycles(5);
        expect_drained("rsb_pre");
        checks++;
        if (seq_state !== 3'd2) begin
            errors++; $display("FAIL rsb_pre_state got %0d expected 2", seq_state);
        end
        #2 rsb = 1'b0;
        #1;
        checks++;
        if (dom_rstb !== 4'h0 || seq_state !== 3'd0 || seq_done !== 1'b0 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL rsb_async got rstb=%b state=%0d done=%b err=%b expected 0000/0/0/0",
                     dom_rstb, seq_state, seq_done, seq_err);
        end
        @(negedge osc_ck);
        rsb = 1'b1;
    endtask

    task automatic test_ack_timeout_coincide();
        start_seq(1, 4'h0);
        push_ev(1, 6'b00_0001);
        run_cycles(17);
        checks++;
        if (seq_state !== 3'd2 || seq_err !== 1'b0) begin
            errors++; $display("FAIL coincide_pre got state=%0d err=%b expected 2/0", seq_state, seq_err);
        end
        ack_force = 4'b0001;
        drive_ack();
        run_cycles(1);
        checks++;
        if (seq_err !== 1'b0 || seq_state !== 3'd1) begin
            errors++; $display("FAIL coincide_ack got err=%b state=%0d expected 0/1", seq_err, seq_state);
        end
        ack_force = 4'b0000;
        push_ev(18, 6'b00_0011);
        run_cycles(1);
        expect_drained("coincide");
    endtask

    initial begin
        test_reset();
        test_seq_dly3();
        test_dly_zero();
        test_timeout();
        test_por_abort();
        test_rsb_mid_ack();
        test_ack_timeout_coincide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
